cache_ctrl_4way: RTL and testbench

Control FSM for the 4-way set-associative cache with 8 sets and 256-bit blocks. It owns the tag, valid, dirty and LRU state and resolves each CPU request as a hit or a miss. On a miss it sequences an optional dirty writeback and then a block fill over a req/ack memory handshake. It drives the set select for the 8-to-1 block mux, the way select and the data-array write strobes.

---
 rtl/cache_ctrl_4way.sv | 114 +++++++++++
 tb/tb_cache_ctrl_4way.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_4way.sv
// cache_ctrl_4way: tag/valid/dirty/LRU control FSM for a 4-way, 8-set cache with writeback and fill sequencing
module cache_ctrl_4way #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic [2:0]        set_sel,
    output logic [1:0]        way_sel,
    output logic              data_we,
    output logic              fill_sel
);
    localparam int TAG_W = ADDR_W - 8;
    localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, WB = 3'd2, FILL = 3'd3, HIT = 3'd4;

    logic [2:0]       state;
    logic             req_we;
    logic             hit_flag;
    logic [TAG_W-1:0] req_tag;
    logic [TAG_W-1:0] tags [8][4];
    logic [3:0]       valid [8];
    logic [3:0]       dirty [8];
    logic [1:0]       age [8][4];
    logic [3:0]       hit_vec;
    logic             hit;
    logic [1:0]       hit_way;
    logic [1:0]       victim;
    logic [1:0]       acc_age;
    logic             unused_offset;

    assign unused_offset = ^cpu_addr[4:0];

    // Invalid ways win over the LRU way, lowest index first.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        victim  = '0;
        for (int i = 3; i >= 0; i--) begin
            hit_vec[i] = valid[set_sel][i] && (tags[set_sel][i] == req_tag);
            if (hit_vec[i]) hit_way = 2'(i);
        end
        for (int i = 0; i < 4; i++)
            if (age[set_sel][i] == 2'd3) victim = 2'(i);
        for (int i = 3; i >= 0; i--)
            if (!valid[set_sel][i]) victim = 2'(i);
    end

    assign hit       = |hit_vec;
    assign acc_age   = age[set_sel][way_sel];
    assign mem_req   = (state == WB) || (state == FILL);
    assign mem_we    = state == WB;
    assign mem_addr  = !mem_req ? '0 : {(mem_we ? tags[set_sel][way_sel] : req_tag), set_sel, 5'b0};
    assign cpu_ready = state == HIT;
    assign cpu_hit   = cpu_ready && hit_flag;
    assign fill_sel  = (state == FILL) && mem_ack;
    assign data_we   = fill_sel || (cpu_ready && req_we);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            req_we   <= 1'b0;
            req_tag  <= '0;
            hit_flag <= 1'b0;
            set_sel  <= '0;
            way_sel  <= '0;
        end else begin
            case (state)
                IDLE: if (cpu_req) begin
                    state   <= LOOKUP;
                    req_we  <= cpu_we;
                    req_tag <= cpu_addr[ADDR_W-1:8];
                    set_sel <= cpu_addr[7:5];
                end
                LOOKUP: begin
                    way_sel  <= hit ? hit_way : victim;
                    hit_flag <= hit;
                    state    <= hit ? HIT : (valid[set_sel][victim] && dirty[set_sel][victim]) ? WB : FILL;
                end
                WB:      if (mem_ack) state <= FILL;
                FILL:    if (mem_ack) state <= HIT;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 8; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < 4; w++) age[s][w] <= 2'(w);
            end
        end else if (fill_sel) begin
            valid[set_sel][way_sel] <= 1'b1;
            dirty[set_sel][way_sel] <= 1'b0;
        end else if (cpu_ready) begin
            if (req_we) dirty[set_sel][way_sel] <= 1'b1;
            for (int w = 0; w < 4; w++)
                if (2'(w) == way_sel) age[set_sel][w] <= '0;
                else if (age[set_sel][w] < acc_age) age[set_sel][w] <= age[set_sel][w] + 2'd1;
        end
    end

    always_ff @(posedge clk)
        if (fill_sel) tags[set_sel][way_sel] <= req_tag;
endmodule

// File: tb/tb_cache_ctrl_4way.sv
// tb_cache_ctrl_4way: scoreboard bench for the 4-way cache control FSM
module tb_cache_ctrl_4way;
    logic        clk = 1'b0, reset = 1'b1, cpu_req = 1'b0, cpu_we = 1'b0, mem_ack = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_ready, cpu_hit, mem_req, mem_we, data_we, fill_sel;
    logic [31:0] mem_addr;
    logic [2:0]  set_sel;
    logic [1:0]  way_sel;
    int checks = 0, failures = 0, cyc = 0, done = 0, last_acc = 0, ack_dly = 0;
    int spur_req = 0, spur_done = 0, fill_cyc = 0, ack_cyc = 0;

    typedef struct packed {logic hit; logic [1:0] way; logic [2:0] set;} rdy_t;
    typedef struct packed {logic fill; logic [1:0] way; logic [2:0] set;} dw_t;
    typedef struct packed {logic we; logic [31:0] addr; logic first;} mem_t;
    rdy_t exp_rdy[$];
    dw_t  exp_dw[$];
    mem_t exp_mem[$];

    cache_ctrl_4way #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .set_sel(set_sel), .way_sel(way_sel),
        .data_we(data_we), .fill_sel(fill_sel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        rdy_t re;
        dw_t  de;
        if (!reset) begin
            if (data_we) begin
                if (exp_dw.size() == 0) check("unexp_data_we", 1, 0);
                else begin
                    de = exp_dw.pop_front();
                    check("dw_fill_sel", fill_sel, de.fill);
                    check("dw_way", way_sel, de.way);
                    check("dw_set", set_sel, de.set);
                    if (fill_sel) begin
                        check("fill_in_ack_cycle", mem_ack, 1);
                        fill_cyc = cyc;
                    end
                end
            end
            if (cpu_ready) begin
                if (exp_rdy.size() == 0) check("unexp_ready", 1, 0);
                else begin
                    re = exp_rdy.pop_front();
                    check("cpu_hit", cpu_hit, re.hit);
                    check("ready_way", way_sel, re.way);
                    check("ready_set", set_sel, re.set);
                    check("ready_latency", cyc, re.hit ? last_acc + 1 : fill_cyc + 1);
                end
                done++;
            end
        end
    end

    // Memory responder: acks ack_dly cycles after a transaction starts.
    initial begin : mem_model
        logic prev;
        bit   active;
        int   cnt;
        mem_t me;
        active = 0;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            prev = mem_ack;
            mem_ack = 1'b0;
            if (!mem_req || reset) begin
                active = 0;
                if (!reset && spur_req != spur_done) begin
                    mem_ack = 1'b1;
                    spur_done++;
                end
            end else begin
                if (!active || prev) begin
                    active = 1;
                    cnt = 0;
                    if (exp_mem.size() == 0) check("unexp_mem_req", 1, 0);
                    else begin
                        me = exp_mem.pop_front();
                        check("mem_we", mem_we, me.we);
                        check("mem_addr", mem_addr, me.addr);
                        check("mem_req_latency", cyc, me.first ? last_acc + 1 : ack_cyc + 1);
                    end
                end
                if (cnt == ack_dly) begin
                    mem_ack = 1'b1;
                    ack_cyc = cyc;
                end
                cnt++;
            end
        end
    end

    task automatic push_exp(input logic we, input logic [31:0] addr, input logic hit,
                            input logic [1:0] way, input logic wb, input logic [31:0] wb_addr);
        logic [2:0] s;
        s = addr[7:5];
        if (!hit) begin
            if (wb) exp_mem.push_back('{1'b1, wb_addr, 1'b1});
            exp_mem.push_back('{1'b0, {addr[31:5], 5'b0}, !wb});
            exp_dw.push_back('{1'b1, way, s});
        end
        if (we) exp_dw.push_back('{1'b0, way, s});
        exp_rdy.push_back('{hit, way, s});
    endtask

    task automatic issue(input logic we, input logic [31:0] addr);
        @(posedge clk);
        #1;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        @(posedge clk);
        #1;
        last_acc = cyc;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = $urandom;
    endtask

    task automatic wait_done();
        int target;
        int n;
        target = done + 1;
        n = 0;
        while (done < target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done < target) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_mem();
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mem_req_seen", mem_req, 1);
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic hit,
                          input logic [1:0] way, input logic wb, input logic [31:0] wb_addr);
        push_exp(we, addr, hit, way, wb, wb_addr);
        issue(we, addr);
        wait_done();
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl_outs", {cpu_ready, cpu_hit, mem_req, mem_we, data_we, fill_sel}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_sel", {set_sel, way_sel}, 0);
        reset = 1'b0;
        ack_dly = 3; access(0, 32'h40, 0, 0, 0, 0);
        ack_dly = 1; access(0, 32'h40, 1, 0, 0, 0);
        ack_dly = 0; access(0, 32'h140, 0, 1, 0, 0);
        ack_dly = 2; access(0, 32'h240, 0, 2, 0, 0);
        ack_dly = 1; access(0, 32'h340, 0, 3, 0, 0);
        access(1, 32'h40, 1, 0, 0, 0);
        access(0, 32'h140, 1, 1, 0, 0);
        access(0, 32'h240, 1, 2, 0, 0);
        access(0, 32'h340, 1, 3, 0, 0);
        access(0, 32'h440, 0, 0, 1, 32'h40);
        ack_dly = 0; access(0, 32'h540, 0, 1, 0, 0);
        spur_req++;
        n = 0;
        while (spur_done != spur_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("spur_ack_sent", spur_done, spur_req);
        @(posedge clk);
        #1;
        check("spur_quiet", {mem_req, cpu_ready, data_we}, 0);
        access(0, 32'h540, 1, 1, 0, 0);
        ack_dly = 3;
        push_exp(0, 32'h640, 0, 2, 0, 0);
        issue(0, 32'h640);
        wait_mem();
        @(posedge clk);
        #1;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 32'h40;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        wait_done();
        repeat (6) @(posedge clk);
        access(0, 32'h640, 1, 2, 0, 0);
        ack_dly = 8;
        push_exp(0, 32'h740, 0, 3, 0, 0);
        issue(0, 32'h740);
        wait_mem();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_outs", {mem_req, data_we, cpu_ready}, 0);
        check("async_rst_sel", {set_sel, way_sel}, 0);
        check("async_rst_mem_popped", exp_mem.size(), 0);
        exp_rdy.delete();
        exp_dw.delete();
        exp_mem.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ack_dly = 1;
        access(0, 32'h40, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        check("queues_empty", exp_rdy.size() + exp_dw.size() + exp_mem.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end
endmodule
